// File: rtl/hazard_npc_ctrl.sv
// Front-end hazard controller: picks the next PC and drives pause/flush/hold controls
// for the PC, IF/ID and ID/EX registers from redirects, load-use hazards and mul/div stalls.
module hazard_npc_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc,
  input  logic             ex_redirect,
  input  logic [31:0]      ex_target,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic             ex_md_start,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  output logic [31:0]      npc,
  output logic             pc_pause,
  output logic             pc_flush,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_hold,
  output logic             idex_flush,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {IDLE, MD_BUSY} state_t;

  localparam logic [3:0] MD_INIT = 4'(MD_LATENCY - 1);

  state_t     state_reg, state_next;
  logic [3:0] md_cnt_reg, md_cnt_next;
  logic       load_use;
  logic       pause_c, flush_c, ifid_hold_c, ifid_flush_c, idex_hold_c, idex_flush_c;

  assign npc = ex_redirect ? ex_target : pc + 32'd4;

  assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    state_next   = state_reg;
    md_cnt_next  = md_cnt_reg;
    pause_c      = 1'b0;
    flush_c      = 1'b0;
    ifid_hold_c  = 1'b0;
    ifid_flush_c = 1'b0;
    idex_hold_c  = 1'b0;
    idex_flush_c = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ex_redirect) begin
          flush_c      = 1'b1;
          ifid_flush_c = 1'b1;
          idex_flush_c = 1'b1;
        end else if (ex_md_start) begin
          pause_c     = 1'b1;
          ifid_hold_c = 1'b1;
          idex_hold_c = 1'b1;
          if (MD_LATENCY > 1) begin
            state_next  = MD_BUSY;
            md_cnt_next = MD_INIT;
          end
        end else if (load_use) begin
          pause_c      = 1'b1;
          ifid_hold_c  = 1'b1;
          idex_flush_c = 1'b1;
        end
      end
      MD_BUSY: begin
        // A redirect here cannot legally happen, but if it does it must still win.
        if (ex_redirect) begin
          flush_c      = 1'b1;
          ifid_flush_c = 1'b1;
          idex_flush_c = 1'b1;
          state_next   = IDLE;
          md_cnt_next  = 4'd0;
        end else begin
          pause_c     = 1'b1;
          ifid_hold_c = 1'b1;
          idex_hold_c = 1'b1;
          md_cnt_next = md_cnt_reg - 4'd1;
          if (md_cnt_reg == 4'd1) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      md_cnt_reg <= 4'd0;
    end else begin
      state_reg  <= state_next;
      md_cnt_reg <= md_cnt_next;
    end
  end

  // Controls are forced low for the whole reset interval, not just after the edge.
  assign pc_pause   = pause_c      && !rst;
  assign pc_flush   = flush_c      && !rst;
  assign ifid_hold  = ifid_hold_c  && !rst;
  assign ifid_flush = ifid_flush_c && !rst;
  assign idex_hold  = idex_hold_c  && !rst;
  assign idex_flush = idex_flush_c && !rst;
  assign md_busy    = (state_reg == MD_BUSY) && !rst;

  logic [1:0]            cnt_inc;
  logic [1:0][CNT_W-1:0] cnt_q;

  assign cnt_inc = {pc_flush, pc_pause};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg <= '0;
        end else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
      assign cnt_q[gi] = cnt_reg;
    end
  endgenerate

  assign stall_cnt = cnt_q[0];
  assign flush_cnt = cnt_q[1];

`ifndef SYNTHESIS
  ap_no_redirect_in_md: assert property (@(posedge clk) disable iff (rst)
    !((state_reg == MD_BUSY) && ex_redirect));
  ap_pc_excl: assert property (@(posedge clk) disable iff (rst) !(pc_pause && pc_flush));
  ap_ifid_excl: assert property (@(posedge clk) disable iff (rst) !(ifid_hold && ifid_flush));
  ap_idex_excl: assert property (@(posedge clk) disable iff (rst) !(idex_hold && idex_flush));
`endif

endmodule

// File: tb/tb_hazard_npc_ctrl.sv
// Directed bench for hazard_npc_ctrl: one instance with MD_LATENCY=4 / 32-bit counters,
// one with MD_LATENCY=1 / 3-bit counters to reach counter saturation quickly.
module tb_hazard_npc_ctrl;

  logic        clk, rst;
  logic [31:0] pc, ex_target;
  logic        ex_redirect, ex_is_load, ex_md_start, id_use_rs1, id_use_rs2;
  logic [4:0]  ex_rd, id_rs1, id_rs2;

  logic [31:0] npc_a, npc_b;
  logic        pp_a, pf_a, ih_a, if_a, eh_a, ef_a, mb_a;
  logic        pp_b, pf_b, ih_b, if_b, eh_b, ef_b, mb_b;
  logic [31:0] sc_a, fc_a;
  logic [2:0]  sc_b, fc_b;

  // Control bundle order: pc_pause, pc_flush, ifid_hold, ifid_flush, idex_hold, idex_flush, md_busy
  logic [6:0] ctl_a, ctl_b;
  assign ctl_a = {pp_a, pf_a, ih_a, if_a, eh_a, ef_a, mb_a};
  assign ctl_b = {pp_b, pf_b, ih_b, if_b, eh_b, ef_b, mb_b};

  localparam logic [6:0] C_NONE  = 7'b0000000;
  localparam logic [6:0] C_LU    = 7'b1010010;
  localparam logic [6:0] C_RDIR  = 7'b0101010;
  localparam logic [6:0] C_MDST  = 7'b1010100;
  localparam logic [6:0] C_MDBSY = 7'b1010101;

  hazard_npc_ctrl #(.MD_LATENCY(4), .CNT_W(32)) u_dut_a (
    .clk(clk), .rst(rst), .pc(pc), .ex_redirect(ex_redirect), .ex_target(ex_target),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_md_start(ex_md_start),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .npc(npc_a), .pc_pause(pp_a), .pc_flush(pf_a), .ifid_hold(ih_a), .ifid_flush(if_a),
    .idex_hold(eh_a), .idex_flush(ef_a), .md_busy(mb_a), .stall_cnt(sc_a), .flush_cnt(fc_a)
  );

  hazard_npc_ctrl #(.MD_LATENCY(1), .CNT_W(3)) u_dut_b (
    .clk(clk), .rst(rst), .pc(pc), .ex_redirect(ex_redirect), .ex_target(ex_target),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_md_start(ex_md_start),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .npc(npc_b), .pc_pause(pp_b), .pc_flush(pf_b), .ifid_hold(ih_b), .ifid_flush(if_b),
    .idex_hold(eh_b), .idex_flush(ef_b), .md_busy(mb_b), .stall_cnt(sc_b), .flush_cnt(fc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_redirect = 1'b0; ex_target = 32'h0; ex_is_load = 1'b0; ex_rd = 5'd0;
    ex_md_start = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
  endtask

  task automatic load_use_rs2();
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
  endtask

  initial begin
    idle_inputs();
    pc  = 32'h100;
    rst = 1'b1;
    load_use_rs2();
    @(negedge clk);
    chk("rst_ctl_a", 64'(ctl_a), 64'(C_NONE));
    chk("rst_npc", 64'(npc_a), 64'h104);
    chk("rst_stall_cnt", 64'(sc_a), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();

    // T1: no hazards
    @(negedge clk);
    chk("t1_npc", 64'(npc_a), 64'h104);
    chk("t1_ctl_a", 64'(ctl_a), 64'(C_NONE));
    tick();
    @(negedge clk);
    chk("t1_stall_cnt", 64'(sc_a), 64'd0);
    chk("t1_flush_cnt", 64'(fc_a), 64'd0);
    tick();

    // T2: load-use on rs2
    load_use_rs2();
    @(negedge clk);
    chk("t2_ctl_a", 64'(ctl_a), 64'(C_LU));
    chk("t2_npc", 64'(npc_a), 64'h104);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("t2_ctl_after", 64'(ctl_a), 64'(C_NONE));
    chk("t2_stall_cnt", 64'(sc_a), 64'd1);
    tick();

    // T3a: load to x0 never stalls
    ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    @(negedge clk);
    chk("t3_rd0_ctl", 64'(ctl_a), 64'(C_NONE));
    tick();

    // T3b: redirect beats load-use
    load_use_rs2();
    ex_redirect = 1'b1; ex_target = 32'h200;
    @(negedge clk);
    chk("t3_rdir_ctl", 64'(ctl_a), 64'(C_RDIR));
    chk("t3_rdir_npc", 64'(npc_a), 64'h200);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("t3_flush_cnt", 64'(fc_a), 64'd1);
    chk("t3_stall_cnt", 64'(sc_a), 64'd1);
    tick();

    // T4: mul/div, 4-cycle stall on A, 1-cycle stall on B
    ex_md_start = 1'b1;
    @(negedge clk);
    chk("t4_start_ctl_a", 64'(ctl_a), 64'(C_MDST));
    chk("t4_start_ctl_b", 64'(ctl_b), 64'(C_MDST));
    tick();
    idle_inputs();
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk($sformatf("t4_busy%0d_ctl_a", i), 64'(ctl_a), 64'(C_MDBSY));
      chk($sformatf("t4_busy%0d_ctl_b", i), 64'(ctl_b), 64'(C_NONE));
      tick();
    end
    @(negedge clk);
    chk("t4_done_ctl_a", 64'(ctl_a), 64'(C_NONE));
    chk("t4_stall_cnt_a", 64'(sc_a), 64'd5);
    chk("t4_stall_cnt_b", 64'(sc_b), 64'd2);
    tick();

    // T5: reset pulse during second MD_BUSY cycle
    ex_md_start = 1'b1;
    tick();
    idle_inputs();
    tick();
    @(negedge clk);
    chk("t5_busy2_ctl_a", 64'(ctl_a), 64'(C_MDBSY));
    rst = 1'b1;
    #1;
    chk("t5_rst_ctl_a", 64'(ctl_a), 64'(C_NONE));
    chk("t5_rst_stall_cnt", 64'(sc_a), 64'd0);
    chk("t5_rst_flush_cnt", 64'(fc_a), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_post_ctl_a", 64'(ctl_a), 64'(C_NONE));
    tick();
    @(negedge clk);
    chk("t5_post2_ctl_a", 64'(ctl_a), 64'(C_NONE));
    chk("t5_post_stall_cnt", 64'(sc_a), 64'd0);
    tick();

    // T6: saturate B's 3-bit stall counter (6 = all-ones-1, then 7 sticks)
    load_use_rs2();
    repeat (6) tick();
    @(negedge clk);
    chk("t6_sat_pre_b", 64'(sc_b), 64'd6);
    repeat (3) begin
      tick();
      @(negedge clk);
      chk("t6_sat_b", 64'(sc_b), 64'd7);
    end
    chk("t6_nosat_a", 64'(sc_a), 64'd9);
    tick();
    idle_inputs();
    pc = 32'hFFFF_FFFC;
    @(negedge clk);
    chk("t6_npc_wrap", 64'(npc_a), 64'h0);
    chk("t6_ctl_a", 64'(ctl_a), 64'(C_NONE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
